wb_write_queue: RTL and testbench
=================================

Name: wb_write_queue

Overview:
- Writer-side initiator for the register file's single write port. It drives `we`, `waddr` and `wdata` to the register file.
- Accepts writeback requests from the MEM/WB stage over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains at most one entry per cycle into the register file, and stalls draining whenever the port is borrowed by another writer (`wb_hold`).
- Gives decode two combinational lookup ports that return the newest still-pending write to a register, so decode can forward it.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- DATA_W, 32, data width (matches RegBus).
- ADDR_W, 5, register address width (matches RegAddrBus).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  writeback request valid.
- in_ready  out  1  queue can accept a request.
- in_waddr  in  ADDR_W  destination register.
- in_wdata  in  DATA_W  write data.
- wb_hold  in  1  register file write port is borrowed this cycle; do not drain.
- we  out  1  register file write enable.
- waddr  out  ADDR_W  register file write address.
- wdata  out  DATA_W  register file write data.
- q_addr1  in  ADDR_W  lookup address, port 1.
- q_hit1  out  1  a pending write exists for q_addr1.
- q_data1  out  DATA_W  data of the newest pending write to q_addr1.
- q_addr2  in  ADDR_W  lookup address, port 2.
- q_hit2  out  1  a pending write exists for q_addr2.
- q_data2  out  DATA_W  data of the newest pending write to q_addr2.
- count  out  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers and count go to 0 and all entry valid bits clear.
  - Outputs during reset: we=0, waddr=0, wdata=0, q_hit*=0, q_data*=0, in_ready=0.
  - Reset asserted mid-operation discards all pending entries with no partial write.
  - After release, in_ready=1 in the first cycle.
- Accept:
  - A request is accepted when in_valid && in_ready at the clock edge.
  - in_ready = (count < DEPTH). It is derived from registered count only, so there is no same-cycle pass-through when the queue is full.
  - A request with in_waddr==0 is accepted but dropped: nothing is enqueued and count does not change.
- Drain:
  - we = (count != 0) && !wb_hold.
  - waddr and wdata come from the head entry, which is register storage, so the outputs carry no combinational path from in_*.
  - When we=1 the head is dequeued at the edge. The register file always accepts the write.
  - Latency: a request accepted at edge N appears on we/waddr/wdata in cycle N+1 if the queue was empty and wb_hold is low.
  - When we=0, waddr and wdata are 0.
- Simultaneous enqueue and dequeue in the same cycle leaves count unchanged.
- FIFO order is preserved strictly.
- Pointers wrap modulo DEPTH.
- count never exceeds DEPTH and never underflows.
- Lookup (combinational):
  - The search covers all occupied entries, head included, and selects the newest (closest to tail) whose address matches q_addr.
  - q_addr == 0 always returns hit=0, data=0.
  - On a miss, data is 0.
  - Incoming in_* requests are not visible to lookup until they are enqueued.
- wb_hold held indefinitely: the queue fills, in_ready drops, and contents are retained unchanged.

Optional Feature:
- Macro: WB_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, wb_hold=0 and in_valid=1 with in_waddr!=0, the request drives we/waddr/wdata in the same cycle and is not enqueued. Latency is 0.
  - in_ready is unchanged.
  - Lookup does not report the bypassed request; the register file's own write-to-read bypass covers it.
- Undefined: the minimum latency is 1 cycle, as described above.

Decomposition:
- Shared defines: RegBus, RegAddrBus, RegNumLog2, ZeroWord, WriteEnable, WriteDisable, and the queue depth constant WbQueueDepth.
- Sub-module wb_fwd_match:
  - Purely combinational priority search over the entry arrays.
  - Takes the entry arrays, valid mask, tail pointer and query address; returns hit and data.
  - Instantiated twice, once per lookup port.

Test Plan:
- Reset, then a single request (addr 3, data 0xDEADBEEF) with wb_hold=0 → next cycle we=1, waddr=3, wdata=0xDEADBEEF; the cycle after, we=0 and count=0.
- wb_hold=1 while enqueuing addr 1..4 (data 0x11..0x44) → count=4 and in_ready=0; a 5th request with in_valid=1 is not accepted. Release wb_hold → four writes in order 1,2,3,4 on consecutive cycles.
- With hold, enqueue (5,0xA) then (5,0xB) → q_addr1=5 gives q_hit1=1, q_data1=0xB. After one drain it still gives 0xB. After the second drain, q_hit1=0.
- Enqueue addr 0 with data 0x1234 → count stays 0, we is never asserted, and q_addr=0 gives hit=0.
- Queue holding 3 entries, rst pulled low asynchronously mid-cycle → we=0 and count=0 immediately (before the next edge); after release, no stale writes appear.
- With WB_QUEUE_BYPASS_EN, empty queue, request (7,0x77) → we=1, waddr=7, wdata=0x77 in the same cycle, and count stays 0.

Source files
------------

// File: rtl/wb_write_queue_pkg.sv
// ---------------------------------------------------------------------------
// wb_write_queue_pkg
// Shared constants for the register-file writeback path: bus widths, the
// zero word, write-enable encodings and the default writeback queue depth.
// No ports (package only).
// ---------------------------------------------------------------------------
package wb_write_queue_pkg;

    localparam int RegBus       = 32;  // register data width
    localparam int RegAddrBus   = 5;   // register address width
    localparam int RegNumLog2   = 5;   // log2 of the number of registers
    localparam int WbQueueDepth = 4;   // default writeback queue depth

    localparam logic [RegBus-1:0] ZeroWord     = '0;
    localparam logic              WriteEnable  = 1'b1;
    localparam logic              WriteDisable = 1'b0;

endpackage

// File: rtl/wb_write_queue_fwd_match.sv
// ---------------------------------------------------------------------------
// wb_fwd_match
// Combinational priority search over the writeback queue storage. Returns
// the newest valid entry (closest to the tail) whose address equals q_addr.
//
// Ports:
//   ent_addr  in  per-entry destination register
//   ent_data  in  per-entry write data
//   ent_valid in  per-entry occupied bit
//   tail      in  next write slot; the newest entry sits at tail-1
//   q_addr    in  lookup address (0 never hits)
//   hit       out a matching pending write exists
//   data      out data of the newest match, 0 on a miss
// ---------------------------------------------------------------------------
module wb_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
    input  logic [DEPTH-1:0]             ent_valid,
    input  logic [$clog2(DEPTH)-1:0]     tail,
    input  logic [ADDR_W-1:0]            q_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk from the oldest slot (tail-DEPTH == tail) to the newest
    // (tail-1); a later match overrides an earlier one, so the newest wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (q_addr != '0) begin
            for (int k = DEPTH; k >= 1; k--) begin
                idx = tail - PTR_W'(k);
                if (ent_valid[idx] && (ent_addr[idx] == q_addr)) begin
                    hit  = 1'b1;
                    data = ent_data[idx];
                end
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// ---------------------------------------------------------------------------
// wb_write_queue
// In-order writeback buffer in front of the register file's single write
// port, with two forwarding lookup ports for decode.
//
// Optional feature macro: WB_QUEUE_BYPASS_EN -- when defined, a request
// arriving at an empty, unheld queue is written straight through in the
// same cycle instead of being enqueued.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   in_valid/in_ready        writeback request handshake
//   in_waddr, in_wdata       request address / data (addr 0 is dropped)
//   wb_hold                  write port borrowed this cycle; no drain
//   we, waddr, wdata         register file write port
//   q_addr1/q_hit1/q_data1   forwarding lookup, port 1
//   q_addr2/q_hit2/q_data2   forwarding lookup, port 2
//   count                    number of occupied entries
//
// Handshake: a request transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on registered state.
// ---------------------------------------------------------------------------
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH  = WbQueueDepth,
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_waddr,
    input  logic [DATA_W-1:0]        in_wdata,
    input  logic                     wb_hold,
    output logic                     we,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        wdata,
    input  logic [ADDR_W-1:0]        q_addr1,
    output logic                     q_hit1,
    output logic [DATA_W-1:0]        q_data1,
    input  logic [ADDR_W-1:0]        q_addr2,
    output logic                     q_hit2,
    output logic [DATA_W-1:0]        q_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0]             ent_valid;
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [CNT_W-1:0]             cnt;

    logic deq;
    logic enq;
    logic bypass;

    // Gated by rst so the port reads as not-ready while reset is held.
    assign in_ready = rst && (cnt < CNT_W'(DEPTH));
    assign deq      = rst && (cnt != '0) && !wb_hold;
    assign count    = cnt;

`ifdef WB_QUEUE_BYPASS_EN
    assign bypass = rst && (cnt == '0) && !wb_hold && in_valid && (in_waddr != '0);
`else
    assign bypass = 1'b0;
`endif

    // Address-0 writes are architecturally void: accepted, never stored.
    assign enq = in_valid && in_ready && (in_waddr != '0) && !bypass;

    always_comb begin
        we    = WriteDisable;
        waddr = '0;
        wdata = '0;
        if (deq) begin
            we    = WriteEnable;
            waddr = ent_addr[head];
            wdata = ent_data[head];
        end else if (bypass) begin
            we    = WriteEnable;
            waddr = in_waddr;
            wdata = in_wdata;
        end
    end

    // enq and deq never touch the same slot: head==tail means empty
    // (no deq) or full (no enq).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            ent_valid <= '0;
            ent_addr  <= '0;
            ent_data  <= '0;
        end else begin
            if (enq) begin
                ent_addr[tail]  <= in_waddr;
                ent_data[tail]  <= in_wdata;
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (deq) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match1 (
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_valid (ent_valid),
        .tail      (tail),
        .q_addr    (q_addr1),
        .hit       (q_hit1),
        .data      (q_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match2 (
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_valid (ent_valid),
        .tail      (tail),
        .q_addr    (q_addr2),
        .hit       (q_hit2),
        .data      (q_data2)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_write_queue
// Self-checking bench for wb_write_queue: directed scenarios followed by a
// randomized phase, all outputs compared every cycle against a queue-based
// reference model.
// ---------------------------------------------------------------------------
module tb_wb_write_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_waddr;
    logic [DATA_W-1:0] in_wdata;
    logic              wb_hold;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] q_addr1;
    logic              q_hit1;
    logic [DATA_W-1:0] q_data1;
    logic [ADDR_W-1:0] q_addr2;
    logic              q_hit2;
    logic [DATA_W-1:0] q_data2;
    logic [2:0]        count;

    wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_waddr (in_waddr),
        .in_wdata (in_wdata),
        .wb_hold  (wb_hold),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .q_addr1  (q_addr1),
        .q_hit1   (q_hit1),
        .q_data1  (q_data1),
        .q_addr2  (q_addr2),
        .q_hit2   (q_hit2),
        .q_data2  (q_data2),
        .count    (count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // last sampled DUT outputs, for directed spot checks
    logic              s_we, s_ready, s_hit1;
    logic [ADDR_W-1:0] s_waddr;
    logic [DATA_W-1:0] s_wdata, s_data1;
    logic [2:0]        s_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // newest pending write to qa, searched from the back of the model queue
    task automatic model_lookup(input logic [ADDR_W-1:0] qa, output logic h, output logic [DATA_W-1:0] d);
        h = 1'b0;
        d = '0;
        if (qa != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a == qa) begin
                    h = 1'b1;
                    d = mq[i].d;
                    break;
                end
            end
        end
    endtask

    // One clock cycle: drive at negedge, compare at negedge+1, update model at posedge.
    task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic h, input logic [ADDR_W-1:0] qa1, input logic [ADDR_W-1:0] qa2);
        logic              e_rdy, e_we, bp, drain, e_h1, e_h2;
        logic [ADDR_W-1:0] e_wa;
        logic [DATA_W-1:0] e_wd, e_d1, e_d2;
        @(negedge clk);
        in_valid = v;
        in_waddr = a;
        in_wdata = d;
        wb_hold  = h;
        q_addr1  = qa1;
        q_addr2  = qa2;
        #1;
        e_rdy = (mq.size() < DEPTH);
        drain = (mq.size() != 0) && !h;
        bp    = 1'b0;
`ifdef WB_QUEUE_BYPASS_EN
        bp = (mq.size() == 0) && !h && v && (a != '0);
`endif
        e_we = drain || bp;
        e_wa = '0;
        e_wd = '0;
        if (drain) begin
            e_wa = mq[0].a;
            e_wd = mq[0].d;
        end else if (bp) begin
            e_wa = a;
            e_wd = d;
        end
        model_lookup(qa1, e_h1, e_d1);
        model_lookup(qa2, e_h2, e_d2);
        check("in_ready", 32'(in_ready), 32'(e_rdy));
        check("count",    32'(count),    32'(mq.size()));
        check("we",       32'(we),       32'(e_we));
        check("waddr",    32'(waddr),    32'(e_wa));
        check("wdata",    wdata,         e_wd);
        check("q_hit1",   32'(q_hit1),   32'(e_h1));
        check("q_data1",  q_data1,       e_d1);
        check("q_hit2",   32'(q_hit2),   32'(e_h2));
        check("q_data2",  q_data2,       e_d2);
        s_we = we; s_ready = in_ready; s_hit1 = q_hit1;
        s_waddr = waddr; s_wdata = wdata; s_data1 = q_data1; s_count = count;
        @(posedge clk);
        if (drain) void'(mq.pop_front());
        if (v && e_rdy && (a != '0) && !bp) mq.push_back('{a: a, d: d});
    endtask

    task automatic idle(input logic h, input logic [ADDR_W-1:0] qa1);
        step(1'b0, '0, '0, h, qa1, '0);
    endtask

    int hold_run;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_waddr = '0; in_wdata = '0;
        wb_hold = 1'b0; q_addr1 = '0; q_addr2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we",    32'(we),       32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_count", 32'(count),    32'd0);
        check("rst_hit1",  32'(q_hit1),   32'd0);
        rst = 1'b1;

        // single request, write-through latency
        step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd3, 5'd0);
`ifdef WB_QUEUE_BYPASS_EN
        check("t1_bp_we",    32'(s_we),    32'd1);
        check("t1_bp_waddr", 32'(s_waddr), 32'd3);
        idle(1'b0, 5'd0);
        check("t1_bp_cnt",   32'(s_count), 32'd0);
`else
        check("t1_ready0", 32'(s_ready), 32'd1);
        idle(1'b0, 5'd0);
        check("t1_we",    32'(s_we),    32'd1);
        check("t1_waddr", 32'(s_waddr), 32'd3);
        check("t1_wdata", s_wdata,      32'hDEADBEEF);
        idle(1'b0, 5'd0);
        check("t1_we_off", 32'(s_we),    32'd0);
        check("t1_cnt",    32'(s_count), 32'd0);
`endif

        // fill under hold, overflow attempt, ordered drain
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(i * 'h11), 1'b1, 5'(i), 5'd0);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0);
        check("fill_cnt",   32'(s_count), 32'd4);
        check("fill_ready", 32'(s_ready), 32'd0);
        check("fill_nohit", 32'(s_hit1),  32'd0);
        for (int i = 1; i <= 4; i++) begin
            idle(1'b0, 5'd0);
            check("drain_addr", 32'(s_waddr), 32'(i));
            check("drain_data", s_wdata,      32'(i * 'h11));
        end
        idle(1'b0, 5'd0);

        // newest-match forwarding
        step(1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 5'd0);
        step(1'b1, 5'd5, 32'hB, 1'b1, 5'd5, 5'd0);
        idle(1'b1, 5'd5);
        check("fwd_hit",  32'(s_hit1), 32'd1);
        check("fwd_data", s_data1,     32'hB);
        idle(1'b0, 5'd5);
        idle(1'b1, 5'd5);
        check("fwd_hit_d1",  32'(s_hit1), 32'd1);
        check("fwd_data_d1", s_data1,     32'hB);
        idle(1'b0, 5'd5);
        idle(1'b0, 5'd5);
        check("fwd_miss", 32'(s_hit1), 32'd0);

        // address 0 is dropped
        step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0);
        check("a0_we", 32'(s_we), 32'd0);
        idle(1'b0, 5'd0);
        check("a0_cnt",  32'(s_count), 32'd0);
        check("a0_we2",  32'(s_we),    32'd0);
        check("a0_hit",  32'(s_hit1),  32'd0);

        // bypass on an empty queue
        step(1'b1, 5'd7, 32'h77, 1'b0, 5'd7, 5'd0);
`ifdef WB_QUEUE_BYPASS_EN
        check("bp_we",    32'(s_we),    32'd1);
        check("bp_waddr", 32'(s_waddr), 32'd7);
        check("bp_wdata", s_wdata,      32'h77);
        check("bp_nohit", 32'(s_hit1),  32'd0);
        idle(1'b0, 5'd7);
        check("bp_cnt",   32'(s_count), 32'd0);
`else
        check("nobp_we", 32'(s_we), 32'd0);
        idle(1'b0, 5'd7);
`endif
        idle(1'b0, 5'd0);

        // asynchronous reset with three pending entries
        step(1'b1, 5'd9,  32'h900, 1'b1, 5'd9, 5'd0);
        step(1'b1, 5'd10, 32'hA00, 1'b1, 5'd9, 5'd0);
        step(1'b1, 5'd9,  32'h901, 1'b1, 5'd9, 5'd0);
        @(negedge clk);
        in_valid = 1'b0; wb_hold = 1'b0; q_addr1 = 5'd9;
        #2;
        rst = 1'b0;
        #1;
        check("arst_we",    32'(we),       32'd0);
        check("arst_count", 32'(count),    32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        check("arst_hit1",  32'(q_hit1),   32'd0);
        check("arst_data1", q_data1,       32'd0);
        check("arst_waddr", 32'(waddr),    32'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) idle(1'b0, 5'd9);

        // randomized traffic with hold bursts
        hold_run = 0;
        for (int i = 0; i < 800; i++) begin
            logic h;
            if (hold_run > 0) begin
                hold_run--;
                h = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                hold_run = $urandom_range(1, 10);
                h = 1'b1;
            end else begin
                h = ($urandom_range(0, 3) == 0);
            end
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, h,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
